// File: rtl/fi_bus_responder_if.sv
// Multi-channel req/gnt/recv/ack bus bundle shared by a requester (master)
// and the fi_bus_responder (slave).
interface fi_bus_responder_if #(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]    req;
  logic [NCH*AW-1:0] addr;
  logic [NCH-1:0]    ack;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    recv;
  logic [NCH-1:0]    error;
  logic [NCH*DW-1:0] rdata;
  logic [NCH-1:0]    viol;

  modport master (
    output req, addr, ack,
    input  gnt, recv, error, rdata, viol
  );

  modport slave (
    input  req, addr, ack,
    output gnt, recv, error, rdata, viol
  );
endinterface

// File: rtl/fi_bus_responder.sv
// Protocol-safe bus responder: free-choice inputs are gated so each channel's
// gnt/recv/error/rdata obey req/gnt/recv/ack with bounded stalls.
module fi_bus_responder #(
  parameter int NCH           = 2,
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int DEPTH         = 2,
  parameter int MAX_GNT_STALL = 3,
  parameter int MAX_RSP_STALL = 3,
  parameter int ERR_EN        = 1
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  fi_bus_responder_if.slave     bus,
  input  logic [NCH-1:0]        gnt_choice,
  input  logic [NCH-1:0]        recv_choice,
  input  logic [NCH-1:0]        err_choice,
  input  logic [NCH*DW-1:0]     rdata_choice
);

  localparam int OW  = $clog2(DEPTH + 1);
  localparam int GW  = (MAX_GNT_STALL > 0) ? $clog2(MAX_GNT_STALL + 1) : 1;
  localparam int RW  = (MAX_RSP_STALL > 0) ? $clog2(MAX_RSP_STALL + 1) : 1;
  // rstall holds the idle cycles already elapsed, so the current cycle is
  // the MAX_RSP_STALL-th one when rstall reaches MAX_RSP_STALL-1.
  localparam int RSL = (MAX_RSP_STALL > 0) ? MAX_RSP_STALL - 1 : 0;
  localparam logic ERR_EN_B = (ERR_EN != 0);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [OW-1:0] outst_reg, outst_next;
      logic [GW-1:0] gstall_reg, gstall_next;
      logic [RW-1:0] rstall_reg, rstall_next;
      logic [0:0]    state_reg, state_next;
      logic          error_reg;
      logic [DW-1:0] rdata_reg;
      logic          req_q_reg, gnt_q_reg;
      logic [AW-1:0] addr_q_reg;
      logic          viol_reg, viol_next;

      logic          req_w, ack_w, gnt_w, recv_w;
      logic [AW-1:0] addr_w;
      logic          room, gforce, rforce, start, done, accept;

      assign req_w  = bus.req[gi];
      assign ack_w  = bus.ack[gi];
      assign addr_w = bus.addr[gi*AW +: AW];
      assign recv_w = (state_reg == ST_HOLD);

      assign room   = (outst_reg < OW'(DEPTH));
      assign gforce = (gstall_reg == GW'(MAX_GNT_STALL));
      // A forced grant still waits for room; reset masks any stale choice.
      assign gnt_w  = g_resetn & req_w & room & (gnt_choice[gi] | gforce);
      assign accept = req_w & gnt_w;
      assign done   = recv_w & ack_w;
      assign rforce = (MAX_RSP_STALL == 0) || (rstall_reg == RW'(RSL));
      assign start  = (state_reg == ST_IDLE) && (outst_reg != '0) &&
                      (recv_choice[gi] || rforce);

      always_comb begin
        outst_next = outst_reg;
        if (accept && !done) begin
          outst_next = outst_reg + OW'(1);
        end else if (!accept && done) begin
          outst_next = outst_reg - OW'(1);
        end

        gstall_next = gstall_reg;
        if (!req_w || gnt_w) begin
          gstall_next = '0;
        end else if (!gforce) begin
          gstall_next = gstall_reg + GW'(1);
        end

        rstall_next = rstall_reg;
        if (state_reg == ST_HOLD || start || outst_reg == '0) begin
          rstall_next = '0;
        end else if (rstall_reg != RW'(RSL)) begin
          rstall_next = rstall_reg + RW'(1);
        end

        state_next = state_reg;
        if (start) begin
          state_next = ST_HOLD;
        end else if (done) begin
          state_next = ST_IDLE;
        end

        // Requester-side errors: drop or address change while ungranted,
        // and ack with no response presented.
        viol_next = viol_reg
                  | (req_q_reg & ~gnt_q_reg & ~req_w)
                  | (req_q_reg & ~gnt_q_reg & req_w & (addr_w != addr_q_reg))
                  | (ack_w & ~recv_w);
      end

      always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
          outst_reg  <= '0;
          gstall_reg <= '0;
          rstall_reg <= '0;
          state_reg  <= ST_IDLE;
          error_reg  <= 1'b0;
          rdata_reg  <= '0;
          req_q_reg  <= 1'b0;
          gnt_q_reg  <= 1'b0;
          addr_q_reg <= '0;
          viol_reg   <= 1'b0;
        end else begin
          outst_reg  <= outst_next;
          gstall_reg <= gstall_next;
          rstall_reg <= rstall_next;
          state_reg  <= state_next;
          req_q_reg  <= req_w;
          gnt_q_reg  <= gnt_w;
          addr_q_reg <= addr_w;
          viol_reg   <= viol_next;
          if (start) begin
            rdata_reg <= rdata_choice[gi*DW +: DW];
            error_reg <= err_choice[gi] & ERR_EN_B;
          end
        end
      end

      assign bus.gnt[gi]             = gnt_w;
      assign bus.recv[gi]            = recv_w;
      assign bus.error[gi]           = error_reg;
      assign bus.rdata[gi*DW +: DW]  = rdata_reg;
      assign bus.viol[gi]            = viol_reg;
    end
  endgenerate

endmodule
